ef_sram_array_ctrl: RTL

Parametrised controller for a bank of NM EF 1024x32-class SRAM macros, tiled in depth. It presents one valid/ready request port and one valid/ready read-response port. The block handles macro selection, byte-mask to bit-enable expansion, power-up sequencing of WLOFF, and read-response buffering with credit-based backpressure. It sits between the SoC bus adapter and the per-macro wrappers; it is the multi-macro, handshaked successor of the single-macro wrapper.

---
 rtl/ef_sram_pkg.sv | 23 ++
 rtl/ef_sram_rsp_fifo.sv | 52 +++++
 rtl/ef_sram_array_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ef_sram_pkg.sv
// Shared types, default geometry and helpers for the EF SRAM array controller.
package ef_sram_pkg;

  localparam int DEF_NB        = 32;
  localparam int DEF_NA        = 10;
  localparam int DEF_NM        = 4;
  localparam int DEF_PWRUP_CYC = 16;

  localparam int NBY  = DEF_NB / 8;
  localparam int NSEL = $clog2(DEF_NM);
  localparam int AW   = DEF_NA + NSEL;

  typedef enum logic {
    PWRUP = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One mask bit becomes the eight bit-enables of its byte lane.
  function automatic logic [7:0] byte_bit_en(input logic mask_bit);
    return {8{mask_bit}};
  endfunction

endpackage

// File: rtl/ef_sram_rsp_fifo.sv
// Two-entry synchronous FIFO that buffers read data between macro capture and the response port.
module ef_sram_rsp_fifo #(
  parameter int W = 32
) (
  input  logic         CLKin,
  input  logic         RSTin,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: the storage array has no reset; only pointers and count do, and the head is ignored while empty.
  always_ff @(posedge CLKin) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rptr];
  assign o_full     = (r_count == 2'd2);
  assign o_empty    = (r_count == 2'd0);
  assign o_count    = r_count;

endmodule

// File: rtl/ef_sram_array_ctrl.sv
// Handshaked controller for NM depth-tiled EF SRAM macros: decode, bit enables,
// WLOFF power-up sequencing and credit-limited read-response buffering.
module ef_sram_array_ctrl
  import ef_sram_pkg::*;
#(
  parameter int NB        = DEF_NB,
  parameter int NA        = DEF_NA,
  parameter int NM        = DEF_NM,
  parameter int PWRUP_CYC = DEF_PWRUP_CYC,
  localparam int NBYTE    = NB / 8,
  localparam int NSELB    = $clog2(NM),
  localparam int SELW     = (NSELB > 0) ? NSELB : 1,
  localparam int ADW      = NA + NSELB
) (
  input  logic             CLKin,
  input  logic             RSTin,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADW-1:0]   req_addr,
  input  logic [NB-1:0]    req_wdata,
  input  logic [NBYTE-1:0] req_wmask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NB-1:0]    rsp_rdata,
  output logic             init_done,
  output logic [NM-1:0]    sram_EN,
  output logic             sram_R_WB,
  output logic [NA-1:0]    sram_AD,
  output logic [NB-1:0]    sram_DI,
  output logic [NB-1:0]    sram_BEN,
  input  logic [NM*NB-1:0] sram_DO,
  output logic             sram_WLOFF,
  output logic             sram_TM,
  output logic             sram_SM,
  output logic             sram_WLBI,
  output logic             sram_ScanInCC,
  output logic             sram_ScanInDL,
  output logic             sram_ScanInDR
);

  localparam int CNTW = $clog2(PWRUP_CYC + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_pwr_cnt;
  logic            w_run;

  logic [SELW-1:0] w_bank;
  logic [SELW-1:0] r_bank;
  logic            w_fire;
  logic            w_rd_fire;
  logic            r_rd_pending;
  logic [NB-1:0]   w_capture;

  logic            w_push;
  logic            w_pop;
  logic [NB-1:0]   w_fifo_rdata;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [1:0]      w_fifo_count;
  logic [2:0]      w_outstanding;

  // NOTE: every flop is written with <= so all registers sample pre-edge values together.
  always_ff @(posedge CLKin) begin
    if (RSTin) r_state <= PWRUP;
    else       r_state <= w_state_nxt;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PWRUP:   if (r_pwr_cnt == CNTW'(PWRUP_CYC - 1)) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = PWRUP;
    endcase
  end

  always_comb begin
    sram_WLOFF = 1'b1;
    init_done  = 1'b0;
    if (r_state == RUN) begin
      sram_WLOFF = 1'b0;
      init_done  = 1'b1;
    end
  end

  always_ff @(posedge CLKin) begin
    if (RSTin)                 r_pwr_cnt <= '0;
    else if (r_state == PWRUP) r_pwr_cnt <= r_pwr_cnt + 1'b1;
  end

  assign w_run = (r_state == RUN);

  generate
    if (NSELB > 0) begin : g_bank_sel
      assign w_bank = req_addr[ADW-1:NA];
    end else begin : g_single_bank
      assign w_bank = 1'b0;
    end
  endgenerate

  // Credits count reads in flight plus buffered responses; a same-cycle pop frees one.
  assign w_pop         = rsp_valid & rsp_ready;
  assign w_outstanding = {2'b00, r_rd_pending} + {1'b0, w_fifo_count};
  assign req_ready     = w_run && ((w_outstanding - {2'b00, w_pop}) < 3'd2);

  assign w_fire    = req_valid & req_ready;
  assign w_rd_fire = w_fire & ~req_we;

  always_comb begin
    sram_EN = '0;
    if (w_fire && (!req_we || (|req_wmask))) sram_EN[w_bank] = 1'b1;
  end

  always_comb begin
    sram_BEN = '0;
    for (int i = 0; i < NBYTE; i++) begin
      sram_BEN[i*8 +: 8] = req_we ? byte_bit_en(req_wmask[i]) : 8'h00;
    end
  end

  assign sram_R_WB     = ~req_we;
  assign sram_AD       = req_addr[NA-1:0];
  assign sram_DI       = req_wdata;
  assign sram_TM       = 1'b0;
  assign sram_SM       = 1'b0;
  assign sram_WLBI     = 1'b0;
  assign sram_ScanInCC = 1'b0;
  assign sram_ScanInDL = 1'b0;
  assign sram_ScanInDR = 1'b0;

  // The bank of an accepted read is remembered so its macro output can be picked a cycle later.
  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      r_rd_pending <= 1'b0;
      r_bank       <= '0;
    end else begin
      r_rd_pending <= w_rd_fire;
      if (w_rd_fire) r_bank <= w_bank;
    end
  end

  assign w_capture = sram_DO[int'(r_bank)*NB +: NB];
  assign w_push    = r_rd_pending & (~w_fifo_full | w_pop);

  ef_sram_rsp_fifo #(
    .W (NB)
  ) u_rsp_fifo (
    .CLKin       (CLKin),
    .RSTin       (RSTin),
    .i_push      (w_push),
    .i_push_data (w_capture),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_rdata),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign rsp_valid = ~w_fifo_empty;
  assign rsp_rdata = w_fifo_empty ? '0 : w_fifo_rdata;

endmodule
